// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU (A) and load (B) writeback.
// Optional macro WB_R0_PROTECT_EN suppresses the write enable for transfers targeting register 0.
module wb_port_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [2:0]       a_reg,
  input  logic [15:0]      a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [2:0]       b_reg,
  input  logic [15:0]      b_data,
  output logic             write_en,
  output logic [2:0]       wreg,
  output logic [15:0]      writedata,
  output logic [CNT_W-1:0] wr_count
);

  localparam int DATA_W = 16;

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

  prio_t              prio, prio_nxt;
  logic               a_xfer_p0, b_xfer_p0, xfer_p0, commit_p0;
  logic [2:0]         sel_reg_p0;
  logic [DATA_W-1:0]  sel_data_p0;
  logic               we_p1;
  logic [2:0]         wreg_p1;
  logic [DATA_W-1:0]  wdata_p1;
  logic [CNT_W-1:0]   cnt_p1;

  // Stage p0: combinational grant, readies are held low during reset
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst_n && !stall) begin
      a_ready = a_valid && (!b_valid || prio == PRIO_A);
      b_ready = b_valid && (!a_valid || prio == PRIO_B);
    end
  end

  assign a_xfer_p0   = a_valid && a_ready;
  assign b_xfer_p0   = b_valid && b_ready;
  assign xfer_p0     = a_xfer_p0 || b_xfer_p0;
  assign sel_reg_p0  = a_xfer_p0 ? a_reg  : b_reg;
  assign sel_data_p0 = a_xfer_p0 ? a_data : b_data;

`ifdef WB_R0_PROTECT_EN
  assign commit_p0 = xfer_p0 && (sel_reg_p0 != 3'd0);
`else
  assign commit_p0 = xfer_p0;
`endif

  always_comb begin
    prio_nxt = prio;
    if (a_xfer_p0)      prio_nxt = PRIO_B;
    else if (b_xfer_p0) prio_nxt = PRIO_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio <= PRIO_A;
    else        prio <= prio_nxt;
  end

  // Stage p1: registered write port; a suppressed register-0 write leaves wreg/writedata untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_p1    <= 1'b0;
      wreg_p1  <= 3'd0;
      wdata_p1 <= '0;
      cnt_p1   <= '0;
    end else begin
      we_p1 <= commit_p0;
      if (commit_p0) begin
        wreg_p1  <= sel_reg_p0;
        wdata_p1 <= sel_data_p0;
      end
      if (xfer_p0) cnt_p1 <= cnt_p1 + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign write_en  = we_p1;
  assign wreg      = wreg_p1;
  assign writedata = wdata_p1;
  assign wr_count  = cnt_p1;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: per-cycle vector table plus contention, reset and wrap sequences.
module tb_wb_port_arbiter;

`ifdef WB_R0_PROTECT_EN
  localparam bit R0P = 1'b1;
`else
  localparam bit R0P = 1'b0;
`endif

  logic        clk, rst_n, stall;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [2:0]  a_reg, b_reg, wreg;
  logic [15:0] a_data, b_data, writedata;
  logic        write_en;
  logic [7:0]  wr_count;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .write_en(write_en), .wreg(wreg), .writedata(writedata), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, av, bv;
    logic [2:0]  areg, breg;
    logic [15:0] ad, bd;
    logic        e_ar, e_br, e_we;
    logic [2:0]  e_wreg;
    logic [15:0] e_wd;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic st, av, bv, input logic [2:0] areg, breg,
                              input logic [15:0] ad, bd, input logic e_ar, e_br, e_we,
                              input logic [2:0] e_wreg, input logic [15:0] e_wd,
                              input logic [7:0] e_cnt);
    vec_t v;
    v.st = st; v.av = av; v.bv = bv; v.areg = areg; v.breg = breg; v.ad = ad; v.bd = bd;
    v.e_ar = e_ar; v.e_br = e_br; v.e_we = e_we; v.e_wreg = e_wreg; v.e_wd = e_wd; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_reg = 3'd0; b_reg = 3'd0; a_data = 16'h0; b_data = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // rows: st av bv areg breg ad bd | ar br we wreg wd cnt
    tbl[0]  = mk(0,1,0, 3,0, 16'h1234,16'h0000, 1,0,0, 0,16'h0000, 0);
    tbl[1]  = mk(0,0,0, 3,0, 16'h1234,16'h0000, 0,0,1, 3,16'h1234, 1);
    tbl[2]  = mk(0,1,1, 1,2, 16'h1111,16'h2222, 0,1,0, 3,16'h1234, 1);
    tbl[3]  = mk(0,1,1, 1,2, 16'h1111,16'h2222, 1,0,1, 2,16'h2222, 2);
    tbl[4]  = mk(0,1,1, 1,2, 16'h1111,16'h2222, 0,1,1, 1,16'h1111, 3);
    tbl[5]  = mk(1,1,1, 1,2, 16'h1111,16'h2222, 0,0,1, 2,16'h2222, 4);
    tbl[6]  = mk(1,1,1, 1,2, 16'h1111,16'h2222, 0,0,0, 2,16'h2222, 4);
    tbl[7]  = mk(0,1,1, 1,2, 16'h1111,16'h2222, 1,0,0, 2,16'h2222, 4);
    tbl[8]  = mk(0,0,1, 1,0, 16'h1111,16'hBEEF, 0,1,1, 1,16'h1111, 5);
    tbl[9]  = mk(0,0,0, 1,0, 16'h1111,16'hBEEF, 0,0, !R0P, R0P ? 3'd1 : 3'd0,
                 R0P ? 16'h1111 : 16'hBEEF, 6);
    tbl[10] = mk(0,0,1, 1,5, 16'h1111,16'h5555, 0,1,0, R0P ? 3'd1 : 3'd0,
                 R0P ? 16'h1111 : 16'hBEEF, 6);
    tbl[11] = mk(0,1,1, 1,5, 16'h1111,16'h5555, 1,0,1, 5,16'h5555, 7);
    tbl[12] = mk(0,0,0, 1,5, 16'h1111,16'h5555, 0,0,1, 1,16'h1111, 8);

    // reset state, checked while reset is held with requests pending
    rst_n = 1'b0; stall = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_reg = 3'd7; b_reg = 3'd6; a_data = 16'hFFFF; b_data = 16'hEEEE;
    #12;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_write_en", write_en, 0);
    check("rst_wreg", wreg, 0);
    check("rst_writedata", writedata, 0);
    check("rst_wr_count", wr_count, 0);

    // table-driven cycle-by-cycle vectors
    do_reset();
    for (int i = 0; i < 13; i++) begin
      stall = tbl[i].st; a_valid = tbl[i].av; b_valid = tbl[i].bv;
      a_reg = tbl[i].areg; b_reg = tbl[i].breg; a_data = tbl[i].ad; b_data = tbl[i].bd;
      #1;
      check($sformatf("v%0d_a_ready", i), a_ready, tbl[i].e_ar);
      check($sformatf("v%0d_b_ready", i), b_ready, tbl[i].e_br);
      check($sformatf("v%0d_write_en", i), write_en, tbl[i].e_we);
      check($sformatf("v%0d_wreg", i), wreg, tbl[i].e_wreg);
      check($sformatf("v%0d_writedata", i), writedata, tbl[i].e_wd);
      check($sformatf("v%0d_wr_count", i), wr_count, tbl[i].e_cnt);
      @(negedge clk);
    end

    // contention straight after reset: A,B,A,B with back-to-back writes
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    a_reg = 3'd4; a_data = 16'hA0A0; b_reg = 3'd6; b_data = 16'hB0B0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont%0d_a_ready", i), a_ready, (i % 2 == 0));
      check($sformatf("cont%0d_b_ready", i), b_ready, (i % 2 == 1));
      if (i > 0) begin
        check($sformatf("cont%0d_write_en", i), write_en, 1);
        check($sformatf("cont%0d_wreg", i), wreg, (i % 2 == 1) ? 4 : 6);
        check($sformatf("cont%0d_writedata", i), writedata, (i % 2 == 1) ? 16'hA0A0 : 16'hB0B0);
      end
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("cont4_write_en", write_en, 1);
    check("cont4_wreg", wreg, 6);
    check("cont4_wr_count", wr_count, 4);
    @(negedge clk); #1;
    check("cont5_write_en", write_en, 0);

    // reset lands while a registered write is pending
    do_reset();
    b_valid = 1'b1; b_reg = 3'd2; b_data = 16'h4242;
    @(negedge clk);
    a_valid = 1'b1; a_reg = 3'd3; a_data = 16'h3333;
    #1;
    check("mid_a_ready_prio", a_ready, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_write_en", write_en, 0);
    check("mid_wr_count", wr_count, 0);
    check("mid_wreg", wreg, 0);
    check("mid_a_ready_in_rst", a_ready, 0);
    check("mid_b_ready_in_rst", b_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_prio_a_after", a_ready, 1);
    check("mid_b_after", b_ready, 0);
    @(negedge clk); #1;
    check("mid_resume_we", write_en, 1);
    check("mid_resume_wreg", wreg, 3);

    // counter wrap
    do_reset();
    a_valid = 1'b1; a_reg = 3'd1; a_data = 16'h0001;
    repeat (255) @(posedge clk);
    @(negedge clk); #1;
    check("wrap_255", wr_count, 255);
    @(posedge clk);
    @(negedge clk); #1;
    check("wrap_0", wr_count, 0);
    a_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the accepted-write counter.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port stall, input, 1: pipeline hold; while 1, no grant is issued.
REQ-005 SHALL have port a_valid, input, 1: ALU writeback request.
REQ-006 SHALL have port a_ready, output, 1: ALU request granted this cycle.
REQ-007 SHALL have port a_reg, input, 3: ALU destination register index.
REQ-008 SHALL have port a_data, input, 16: ALU writeback value.
REQ-009 SHALL have ports b_valid (input, 1), b_ready (output, 1), b_reg (input, 3) and b_data (input, 16): load-writeback request, same meanings as the a_* ports.
REQ-010 SHALL have port write_en, output, 1: register-file write enable.
REQ-011 SHALL have port wreg, output, 3: register-file write index.
REQ-012 SHALL have port writedata, output, 16: register-file write value.
REQ-013 SHALL have port wr_count, output, CNT_W: count of accepted transfers.

Function
REQ-014 SHALL share the single register-file write port between requesters A and B, granting at most one per cycle.
REQ-015 SHALL drive a_ready and b_ready combinationally from stall, a_valid, b_valid and the priority state prio (values A or B).
REQ-016 SHALL hold both readies at 0 while stall=1, regardless of the valids.
REQ-017 SHALL, when only one valid is 1 and stall=0, assert that side's ready.
REQ-018 SHALL, when both valids are 1 and stall=0, assert only the ready of the side named by prio.
REQ-019 SHALL keep a ready at 0 whenever its valid is 0.
REQ-020 SHALL treat a transfer as valid&&ready on the same rising edge.
REQ-021 SHALL require each requester to hold valid, reg and data stable until its transfer; a valid withdrawn before transfer produces no write.
REQ-022 SHALL set prio to the non-granted side after every transfer, including single-requester transfers (round-robin), and leave prio unchanged in cycles with no transfer.
REQ-023 SHALL register each transfer: write_en=1 with the winner's reg and data on wreg and writedata exactly one cycle after the handshake edge (latency 1).
REQ-024 SHALL drive write_en=0 in every cycle that follows a no-transfer cycle.
REQ-025 SHALL hold wreg and writedata at their last values while write_en=0.
REQ-026 SHALL sustain back-to-back transfers (one per cycle) with no bubble.
REQ-027 SHALL increment wr_count by 1 per transfer, modulo 2^CNT_W (with CNT_W=8, 255 wraps to 0).
REQ-028 SHALL not compare or merge same-index writes; two writes to the same register commit in grant order.

Reset
REQ-029 SHALL, on rst_n=0, immediately force write_en=0, wreg=0, writedata=0, wr_count=0 and prio=A, independent of clk.
REQ-030 SHALL discard a registered write still pending when reset asserts; it never reaches the register file.
REQ-031 SHALL hold both readies at 0 while rst_n=0.
REQ-032 SHALL resume normal arbitration on the first rising clk edge after rst_n returns to 1.

Configuration
REQ-033 SHALL honour macro WB_R0_PROTECT_EN.
REQ-034 SHALL, with WB_R0_PROTECT_EN defined, still handshake, round-robin and count a transfer to register 0, but keep write_en at 0 for it (register 0 never written).
REQ-035 SHALL, without WB_R0_PROTECT_EN, commit writes to register 0 like any other register.

Verification
REQ-036 SHALL cover single requester: a_valid=1, a_reg=3, a_data=0x1234, stall=0 -> a_ready=1 same cycle; next cycle write_en=1, wreg=3, writedata=0x1234; wr_count=1.
REQ-037 SHALL cover contention: both valid for 4 cycles after reset -> grants A,B,A,B; write_en high for 4 consecutive cycles with matching reg/data.
REQ-038 SHALL cover stall: both valid with stall=1 for 3 cycles -> both readies 0, write_en 0, wr_count unchanged; release -> A granted first.
REQ-039 SHALL cover register 0: b_reg=0, b_data=0xBEEF -> write_en=0 with WB_R0_PROTECT_EN defined, write_en=1 and wreg=0 without it; wr_count increments in both builds.
REQ-040 SHALL cover reset mid-operation: rst_n low between handshake and commit -> write_en stays 0; wr_count=0 and prio=A afterwards.
REQ-041 SHALL cover counter wrap: 256 transfers -> wr_count returns to 0.
